// File: rtl/compute_seq_pkg.sv
// rtl/compute_seq_pkg.sv - shared types and constants for the compute core sequencer
// Instruction layout: INS[4:0], OP1[14:5], OP2[24:15], OP3[34:25].
package compute_seq_pkg;

  localparam int CMD_W   = 35;
  localparam int INS_LSB = 0;
  localparam int INS_MSB = 4;
  localparam int OP1_LSB = 5;
  localparam int OP2_LSB = 15;
  localparam int OP3_LSB = 25;

  typedef logic [INS_MSB-INS_LSB:0] ins_t;
  typedef logic [CMD_W-1:0]         cmd_t;

  localparam ins_t INS_NOP     = 5'd0;
  localparam ins_t INS_TRNG    = 5'd18;
  localparam ins_t INS_AES_ENC = 5'd19;
  localparam ins_t INS_AES_DEC = 5'd20;
  localparam ins_t INS_PADD    = 5'd22;
  localparam ins_t INS_PSUB    = 5'd23;
  localparam ins_t INS_PMUL    = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_e;

  function automatic ins_t get_ins(input cmd_t c);
    return c[INS_MSB:INS_LSB];
  endfunction

endpackage

// File: rtl/compute_core_sequencer_if.sv
// rtl/compute_core_sequencer_if.sv - host command and compute core command bus
// master: host side driving commands and modelling the core; slave: the sequencer.
interface compute_core_sequencer_if #(
  parameter int CMD_W     = 35,
  parameter int LOG_DEPTH = 3
);
  logic [CMD_W-1:0]   cmd_in;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CMD_W-1:0]   core_cmd;
  logic               core_we0;
  logic               core_done;
  logic [LOG_DEPTH:0] fifo_count;
  logic               busy;
  logic               retire_pulse;
  logic [15:0]        retired_cnt;
  logic               timeout_err;

  modport master (
    output cmd_in, cmd_valid, core_done,
    input  cmd_ready, core_cmd, core_we0, fifo_count, busy,
           retire_pulse, retired_cnt, timeout_err
  );

  modport slave (
    input  cmd_in, cmd_valid, core_done,
    output cmd_ready, core_cmd, core_we0, fifo_count, busy,
           retire_pulse, retired_cnt, timeout_err
  );
endinterface

// File: rtl/seq_cmd_fifo.sv
// rtl/seq_cmd_fifo.sv - synchronous command queue with first-word-fall-through head
// Count, full and empty are registered; DEPTH must be a power of two.
module seq_cmd_fifo #(
  parameter int W         = 35,
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid_i,
  input  logic [W-1:0]       wr_data_i,
  output logic               wr_ready_o,
  input  logic               rd_en_i,
  output logic [W-1:0]       rd_data_o,
  output logic               empty_o,
  output logic [LOG_DEPTH:0] count_o
);

  logic [W-1:0]         mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 full_q, empty_q;
  logic                 wr_en, rd_en;

  assign wr_en = wr_valid_i && !full_q;
  assign rd_en = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (LOG_DEPTH+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: flushing the pointers empties the queue.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = !full_q;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign count_o    = count_q;

endmodule

// File: rtl/compute_core_sequencer.sv
// rtl/compute_core_sequencer.sv - issues queued instructions to the compute core, then parks it on a NOP
// Optional wait-state abort enabled by defining SEQ_TIMEOUT_EN.
module compute_core_sequencer
  import compute_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int LOG_DEPTH   = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                        clk,
  input logic                        rst,
  compute_core_sequencer_if.slave    bus
);

  cmd_t       head;
  logic       empty;
  logic       pop;
  logic       timeout_hit;
  logic       timeout_err;

  seq_state_e state_q;
  cmd_t       core_cmd_q;
  logic       core_we0_q;
  logic       retire_q;
  logic       first_wait_q;
  logic [15:0] retired_cnt_q;

  assign pop = (state_q == ST_IDLE) && !empty;

  seq_cmd_fifo #(
    .W         (CMD_W),
    .DEPTH     (FIFO_DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (bus.cmd_valid),
    .wr_data_i  (bus.cmd_in),
    .wr_ready_o (bus.cmd_ready),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .empty_o    (empty),
    .count_o    (bus.fifo_count)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_err_q;

  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q + 32'd1 == 32'(TIMEOUT_CYC));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      core_cmd_q    <= '0;
      core_we0_q    <= 1'b0;
      retire_q      <= 1'b0;
      first_wait_q  <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      core_we0_q <= 1'b0;
      retire_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (get_ins(head) == INS_NOP) begin
              retire_q      <= 1'b1;
              retired_cnt_q <= retired_cnt_q + 16'd1;
            end else begin
              core_cmd_q <= head;
              core_we0_q <= 1'b1;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          first_wait_q <= 1'b1;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          // The core's done still reflects the old command on the first WAIT cycle.
          first_wait_q <= 1'b0;
          if ((bus.core_done && !first_wait_q) || timeout_hit) begin
            core_cmd_q <= '0;
            core_we0_q <= 1'b1;
            state_q    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.core_done) begin
            retire_q      <= 1'b1;
            retired_cnt_q <= retired_cnt_q + 16'd1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_cmd     = core_cmd_q;
  assign bus.core_we0     = core_we0_q;
  assign bus.retire_pulse = retire_q;
  assign bus.retired_cnt  = retired_cnt_q;
  assign bus.timeout_err  = timeout_err;
  assign bus.busy         = (state_q != ST_IDLE) || !empty;

endmodule
